// File: rtl/exe_stage_pkg.sv
// Shared types and constants for the execute stage.
// Bus layouts match the decode and mem stage interfaces.
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 152;
    localparam int ES_TO_MS_BUS_WD = 71;

    localparam int ALU_OP_ADD  = 0;
    localparam int ALU_OP_SUB  = 1;
    localparam int ALU_OP_SLT  = 2;
    localparam int ALU_OP_SLTU = 3;
    localparam int ALU_OP_AND  = 4;
    localparam int ALU_OP_NOR  = 5;
    localparam int ALU_OP_OR   = 6;
    localparam int ALU_OP_XOR  = 7;
    localparam int ALU_OP_SLL  = 8;
    localparam int ALU_OP_SRL  = 9;
    localparam int ALU_OP_SRA  = 10;
    localparam int ALU_OP_LUI  = 11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] alu_op;
        logic        is_div;
        logic        is_signed;
        logic        mfhi;
        logic        mflo;
        logic        load_op;
        logic        mem_we;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] st_data;
    } ds_to_es_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        load_op;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] result;
    } es_to_ms_t;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/exe_stage_div.sv
// Iterative restoring divider, one quotient bit per cycle.
// fin pulses on the last iteration with the sign-corrected results.
module exe_div
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        clear,
    output logic        fin,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_q, state_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;

    logic [32:0] shifted;
    logic        fits;
    logic [31:0] rem_step;
    logic [31:0] quo_step;

    // quo_q doubles as the dividend shift register
    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        fits     = shifted >= {1'b0, dvs_q};
        rem_step = fits ? (shifted[31:0] - dvs_q) : shifted[31:0];
        quo_step = {quo_q[30:0], fits};
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d = DIV_BUSY;
                    rem_d   = '0;
                    quo_d   = abs32(a, is_signed);
                    dvs_d   = abs32(b, is_signed);
                    cnt_d   = '0;
                    negq_d  = is_signed & (a[31] ^ b[31]);
                    negr_d  = is_signed & a[31];
                end
            end
            DIV_BUSY: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (clear) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign fin       = (state_q == DIV_BUSY) && (cnt_q == 5'd31);
    assign done      = (state_q == DIV_DONE);
    assign quotient  = negq_q ? (32'd0 - quo_step) : quo_step;
    assign remainder = negr_q ? (32'd0 - rem_step) : rem_step;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, data-SRAM request, HI/LO and divide sequencing.
// A divide holds the stage until the divider reports done.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       cpu_data_en,
    output logic [3:0]                 cpu_data_wen,
    output logic [31:0]                cpu_data_addr,
    output logic [31:0]                cpu_data_wdata,
    output logic                       es_valid,
    output logic                       es_load_op,
    output logic [4:0]                 es_rf_waddr
);

    logic        es_valid_q, es_valid_d;
    ds_to_es_t   bus_q, bus_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        es_ready_go;
    logic        handoff;
    logic        div_fin;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [31:0] alu_res;
    logic [31:0] es_result;
    es_to_ms_t   out_bus;

    assign es_ready_go    = ~bus_q.is_div | div_done;
    assign es_allowin     = ~es_valid_q | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid_q & es_ready_go;
    assign handoff        = es_to_ms_valid & ms_allowin;

    exe_div u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (es_valid_q & bus_q.is_div),
        .is_signed (bus_q.is_signed),
        .a         (bus_q.src1),
        .b         (bus_q.src2),
        .clear     (handoff),
        .fin       (div_fin),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        es_valid_d = es_allowin ? ds_to_es_valid : es_valid_q;
        bus_d      = bus_q;
        if (es_allowin & ds_to_es_valid) begin
            bus_d = ds_to_es_t'(ds_to_es_bus);
        end
        hi_d = div_fin ? div_rem : hi_q;
        lo_d = div_fin ? div_quo : lo_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            bus_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            bus_q      <= bus_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    always_comb begin
        alu_res = '0;
        unique case (1'b1)
            bus_q.alu_op[ALU_OP_ADD]:  alu_res = bus_q.src1 + bus_q.src2;
            bus_q.alu_op[ALU_OP_SUB]:  alu_res = bus_q.src1 - bus_q.src2;
            bus_q.alu_op[ALU_OP_SLT]:
                alu_res = {31'd0, $signed(bus_q.src1) < $signed(bus_q.src2)};
            bus_q.alu_op[ALU_OP_SLTU]:
                alu_res = {31'd0, bus_q.src1 < bus_q.src2};
            bus_q.alu_op[ALU_OP_AND]:  alu_res = bus_q.src1 & bus_q.src2;
            bus_q.alu_op[ALU_OP_NOR]:  alu_res = ~(bus_q.src1 | bus_q.src2);
            bus_q.alu_op[ALU_OP_OR]:   alu_res = bus_q.src1 | bus_q.src2;
            bus_q.alu_op[ALU_OP_XOR]:  alu_res = bus_q.src1 ^ bus_q.src2;
            bus_q.alu_op[ALU_OP_SLL]:  alu_res = bus_q.src2 << bus_q.src1[4:0];
            bus_q.alu_op[ALU_OP_SRL]:  alu_res = bus_q.src2 >> bus_q.src1[4:0];
            bus_q.alu_op[ALU_OP_SRA]:
                alu_res = $signed(bus_q.src2) >>> bus_q.src1[4:0];
            bus_q.alu_op[ALU_OP_LUI]:  alu_res = {bus_q.src2[15:0], 16'd0};
            default:                   alu_res = '0;
        endcase
    end

    always_comb begin
        es_result = alu_res;
        if (bus_q.mfhi) begin
            es_result = hi_q;
        end else if (bus_q.mflo) begin
            es_result = lo_q;
        end
    end

    always_comb begin
        out_bus.pc       = bus_q.pc;
        out_bus.load_op  = bus_q.load_op;
        out_bus.rf_we    = bus_q.rf_we;
        out_bus.rf_waddr = bus_q.rf_waddr;
        out_bus.result   = es_result;
    end

    assign es_to_ms_bus = out_bus;

    // request only on the handoff cycle so it fires exactly once
    assign cpu_data_en    = handoff & (bus_q.load_op | bus_q.mem_we);
    assign cpu_data_wen   = {4{bus_q.mem_we & cpu_data_en}};
    assign cpu_data_addr  = alu_res;
    assign cpu_data_wdata = bus_q.st_data;

    assign es_valid    = es_valid_q;
    assign es_load_op  = bus_q.load_op;
    assign es_rf_waddr = bus_q.rf_waddr;

endmodule
